// File: rtl/lab4_branch_branch_update_queue_if.sv
// Fetch/resolve handshakes, shared predictor port and redirect
// for the branch update queue.
interface lab4_branch_branch_update_queue_if;
   logic        fetch_val;
   logic        fetch_rdy;
   logic [31:0] fetch_pc;
   logic        fetch_pred;
   logic        resolve_val;
   logic        resolve_rdy;
   logic        resolve_taken;
   logic [31:0] pred_pc;
   logic        pred_prediction;
   logic        pred_update_en;
   logic        pred_update_val;
   logic        mispredict;
   logic [31:0] mispredict_pc;

   modport master (
      output fetch_val,
      input  fetch_rdy,
      output fetch_pc,
      input  fetch_pred,
      output resolve_val,
      input  resolve_rdy,
      output resolve_taken,
      input  pred_pc,
      output pred_prediction,
      input  pred_update_en,
      input  pred_update_val,
      input  mispredict,
      input  mispredict_pc
   );

   modport slave (
      input  fetch_val,
      output fetch_rdy,
      input  fetch_pc,
      output fetch_pred,
      input  resolve_val,
      output resolve_rdy,
      input  resolve_taken,
      output pred_pc,
      input  pred_prediction,
      output pred_update_en,
      output pred_update_val,
      output mispredict,
      output mispredict_pc
   );
endinterface

// File: rtl/lab4_branch_branch_update_queue.sv
// In-order queue of in-flight branch predictions; owns the
// predictor PC port and raises a redirect on mispredict.
module lab4_branch_branch_update_queue #(
   parameter int p_num_entries = 4,
   parameter int p_cnt_nbits   = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   lab4_branch_branch_update_queue_if.slave bus,
   output logic [$clog2(p_num_entries):0]  count,
   output logic [p_cnt_nbits-1:0]          num_resolved,
   output logic [p_cnt_nbits-1:0]          num_mispredicts
);

   localparam int AW = $clog2(p_num_entries);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(p_num_entries);

   logic [31:0]   pc_mem   [p_num_entries];
   logic          pred_mem [p_num_entries];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          mis_q;
   logic [31:0]   mis_pc_q;

   logic          res_rdy;
   logic          res_fire;
   logic          enq_rdy;
   logic          enq_fire;
   logic [31:0]   head_pc;
   logic          head_pred;
   logic          wrong;

   always_comb begin
      head_pc   = pc_mem[head];
      head_pred = pred_mem[head];
      res_rdy   = (count != '0);
      res_fire  = bus.resolve_val && res_rdy;
      // resolve updates own the predictor port, so fetch stalls
      enq_rdy   = (count != FULL) && !res_fire;
      enq_fire  = bus.fetch_val && enq_rdy;
      wrong     = res_fire && (head_pred != bus.resolve_taken);
   end

   always_comb begin
      bus.pred_pc         = bus.fetch_pc;
      bus.pred_update_en  = 1'b0;
      bus.pred_update_val = 1'b0;
      if (res_fire) begin
         bus.pred_pc         = head_pc;
         bus.pred_update_en  = 1'b1;
         bus.pred_update_val = bus.resolve_taken;
      end
   end

   assign bus.fetch_rdy     = enq_rdy;
   assign bus.resolve_rdy   = res_rdy;
   assign bus.fetch_pred    = bus.pred_prediction;
   assign bus.mispredict    = mis_q;
   assign bus.mispredict_pc = mis_pc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         mis_q           <= 1'b0;
         mis_pc_q        <= '0;
         num_resolved    <= '0;
         num_mispredicts <= '0;
      end else begin
         mis_q <= 1'b0;
         if (res_fire) begin
            num_resolved <= num_resolved + 1'b1;
            if (wrong) begin
               // squash head and everything younger
               head            <= '0;
               tail            <= '0;
               count           <= '0;
               mis_q           <= 1'b1;
               mis_pc_q        <= head_pc;
               num_mispredicts <= num_mispredicts + 1'b1;
            end else begin
               head  <= head + 1'b1;
               count <= count - 1'b1;
            end
         end else if (enq_fire) begin
            tail  <= tail + 1'b1;
            count <= count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq_fire) begin
         pc_mem[tail]   <= bus.fetch_pc;
         pred_mem[tail] <= bus.pred_prediction;
      end
   end

endmodule

// File: tb/tb_lab4_branch_branch_update_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_lab4_branch_branch_update_queue;
   localparam int N  = 4;
   localparam int CB = 16;
   localparam int CW = $clog2(N) + 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lab4_branch_branch_update_queue_if bus();
   logic [CW-1:0] count;
   logic [CB-1:0] num_resolved;
   logic [CB-1:0] num_mispredicts;

   lab4_branch_branch_update_queue #(
      .p_num_entries(N),
      .p_cnt_nbits(CB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .count(count),
      .num_resolved(num_resolved),
      .num_mispredicts(num_mispredicts)
   );

   bit pmode;
   assign bus.pred_prediction = pmode ?
      (bus.pred_pc[2] ^ bus.pred_pc[5] ^ bus.pred_pc[8]) : 1'b0;

   function automatic logic pfun(input logic [31:0] pc);
      return pmode ? (pc[2] ^ pc[5] ^ pc[8]) : 1'b0;
   endfunction

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   ent_t        mq[$];
   int unsigned m_res;
   int unsigned m_mis;
   logic        m_mis_q;
   logic [31:0] m_mis_pc;
   logic        e_frdy, e_rrdy, e_uen, e_uval, e_rfire, e_ffire;
   logic [31:0] e_ppc;

   task automatic model_reset();
      mq.delete();
      m_res = 0;
      m_mis = 0;
      m_mis_q = 1'b0;
      m_mis_pc = '0;
   endtask

   task automatic model_eval();
      e_rrdy  = (mq.size() != 0);
      e_rfire = bus.resolve_val && e_rrdy;
      e_frdy  = (mq.size() < N) && !e_rfire;
      e_ffire = bus.fetch_val && e_frdy;
      e_ppc   = e_rfire ? mq[0].pc : bus.fetch_pc;
      e_uen   = e_rfire;
      e_uval  = e_rfire && bus.resolve_taken;
   endtask

   task automatic model_commit();
      ent_t e;
      m_mis_q = 1'b0;
      if (e_rfire) begin
         m_res++;
         e = mq.pop_front();
         if (e.pred != bus.resolve_taken) begin
            m_mis++;
            m_mis_q = 1'b1;
            m_mis_pc = e.pc;
            mq.delete();
         end
      end else if (e_ffire) begin
         mq.push_back('{pc: bus.fetch_pc, pred: pfun(bus.fetch_pc)});
      end
   endtask

   task automatic step(input logic fv, input logic [31:0] fpc,
                       input logic rv, input logic rt);
      bus.fetch_val     = fv;
      bus.fetch_pc      = fpc;
      bus.resolve_val   = rv;
      bus.resolve_taken = rt;
      #1;
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      model_commit();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      step(1'b0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (count !== '0) begin
         n_fail++;
         $display("FAIL reset_count got %0d exp 0", count);
      end
      n_cmp++;
      if (bus.resolve_rdy !== 1'b0 || bus.fetch_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_rdy got r=%b f=%b exp r=0 f=1",
                  bus.resolve_rdy, bus.fetch_rdy);
      end
      n_cmp++;
      if (bus.pred_update_en !== 1'b0 || bus.mispredict !== 1'b0
          || bus.mispredict_pc !== '0) begin
         n_fail++;
         $display("FAIL reset_outs got uen=%b mis=%b mpc=%h exp 0",
                  bus.pred_update_en, bus.mispredict, bus.mispredict_pc);
      end
      n_cmp++;
      if (num_resolved !== '0 || num_mispredicts !== '0) begin
         n_fail++;
         $display("FAIL reset_cnt got %0d/%0d exp 0/0",
                  num_resolved, num_mispredicts);
      end
      advance();
   endtask

   task automatic test_fill();
      pmode = 1'b0;
      for (int i = 0; i < N; i++) begin
         step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
         n_cmp++;
         if (bus.fetch_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_rdy%0d got %b exp 1", i, bus.fetch_rdy);
         end
         advance();
      end
      step(1'b1, 32'h110, 1'b0, 1'b0);
      n_cmp++;
      if (count !== CW'(N) || bus.fetch_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL full got cnt=%0d rdy=%b exp cnt=%0d rdy=0",
                  count, bus.fetch_rdy, N);
      end
      advance();
      n_cmp++;
      if (count !== CW'(N)) begin
         n_fail++;
         $display("FAIL full_hold got %0d exp %0d", count, N);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [6];
      int k;
      exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200, 32'h204};
      k = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2 || i == 3)
            step(1'b1, (i == 2) ? 32'h200 : 32'h204, 1'b0, 1'b0);
         else
            step(1'b0, '0, 1'b1, 1'b0);
         if (i != 2 && i != 3) begin
            n_cmp++;
            if (bus.pred_pc !== exp_pc[k] || bus.pred_update_en !== 1'b1
                || bus.pred_update_val !== 1'b0) begin
               n_fail++;
               $display("FAIL wrap_upd%0d got pc=%h en=%b v=%b exp pc=%h en=1 v=0",
                        k, bus.pred_pc, bus.pred_update_en,
                        bus.pred_update_val, exp_pc[k]);
            end
            k++;
         end
         advance();
         n_cmp++;
         if (bus.mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_mis%0d got 1 exp 0", i);
         end
      end
      step(1'b0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (num_resolved !== CB'(6) || count !== '0) begin
         n_fail++;
         $display("FAIL wrap_end got res=%0d cnt=%0d exp res=6 cnt=0",
                  num_resolved, count);
      end
   endtask

   task automatic test_mispredict();
      pmode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
         advance();
      end
      step(1'b0, '0, 1'b1, 1'b1);
      n_cmp++;
      if (bus.pred_update_en !== 1'b1 || bus.pred_update_val !== 1'b1
          || bus.pred_pc !== 32'h300) begin
         n_fail++;
         $display("FAIL mis_upd got en=%b v=%b pc=%h exp en=1 v=1 pc=300",
                  bus.pred_update_en, bus.pred_update_val, bus.pred_pc);
      end
      advance();
      step(1'b0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.mispredict !== 1'b1 || bus.mispredict_pc !== 32'h300
          || count !== '0 || num_mispredicts !== CB'(1)) begin
         n_fail++;
         $display("FAIL mis_pulse got m=%b pc=%h cnt=%0d nm=%0d exp 1/300/0/1",
                  bus.mispredict, bus.mispredict_pc, count, num_mispredicts);
      end
      advance();
      n_cmp++;
      if (bus.mispredict !== 1'b0) begin
         n_fail++;
         $display("FAIL mis_clear got 1 exp 0");
      end
   endtask

   task automatic test_back_to_back();
      pmode = 1'b0;
      step(1'b1, 32'h400, 1'b0, 1'b0);
      advance();
      step(1'b1, 32'h404, 1'b0, 1'b0);
      advance();
      step(1'b1, 32'h408, 1'b1, 1'b0);
      n_cmp++;
      if (bus.fetch_rdy !== 1'b0 || bus.pred_pc !== 32'h400) begin
         n_fail++;
         $display("FAIL simul got rdy=%b pc=%h exp rdy=0 pc=400",
                  bus.fetch_rdy, bus.pred_pc);
      end
      advance();
      step(1'b1, 32'h408, 1'b0, 1'b0);
      n_cmp++;
      if (count !== CW'(1) || bus.fetch_rdy !== 1'b1
          || bus.pred_pc !== 32'h408 || bus.pred_update_en !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_next got cnt=%0d rdy=%b pc=%h en=%b exp 1/1/408/0",
                  count, bus.fetch_rdy, bus.pred_pc, bus.pred_update_en);
      end
      advance();
      n_cmp++;
      if (count !== CW'(2)) begin
         n_fail++;
         $display("FAIL simul_cnt got %0d exp 2", count);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         advance();
      end
   endtask

   task automatic test_reset_mid();
      pmode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
         advance();
      end
      step(1'b0, '0, 1'b1, 1'b1);
      advance();
      step(1'b0, '0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      step(1'b0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.mispredict !== 1'b0 || count !== '0
          || num_resolved !== '0 || num_mispredicts !== '0) begin
         n_fail++;
         $display("FAIL rst_mid got m=%b cnt=%0d res=%0d mis=%0d exp all 0",
                  bus.mispredict, count, num_resolved, num_mispredicts);
      end
      advance();
   endtask

   task automatic test_random();
      pmode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 6, $urandom() & 32'hFFFF_FFFC,
              $urandom_range(0, 9) < 4, 1'($urandom()));
         n_cmp++;
         if (bus.fetch_rdy !== e_frdy || bus.resolve_rdy !== e_rrdy) begin
            n_fail++;
            $display("FAIL rnd_rdy%0d got f=%b r=%b exp f=%b r=%b",
                     i, bus.fetch_rdy, bus.resolve_rdy, e_frdy, e_rrdy);
         end
         n_cmp++;
         if (bus.pred_pc !== e_ppc || bus.pred_update_en !== e_uen
             || bus.pred_update_val !== e_uval
             || bus.fetch_pred !== pfun(e_ppc)) begin
            n_fail++;
            $display("FAIL rnd_port%0d got pc=%h en=%b v=%b fp=%b exp pc=%h en=%b v=%b fp=%b",
                     i, bus.pred_pc, bus.pred_update_en, bus.pred_update_val,
                     bus.fetch_pred, e_ppc, e_uen, e_uval, pfun(e_ppc));
         end
         advance();
         n_cmp++;
         if (count !== CW'(mq.size()) || bus.mispredict !== m_mis_q) begin
            n_fail++;
            $display("FAIL rnd_state%0d got cnt=%0d m=%b exp cnt=%0d m=%b",
                     i, count, bus.mispredict, mq.size(), m_mis_q);
         end
         if (m_mis_q) begin
            n_cmp++;
            if (bus.mispredict_pc !== m_mis_pc) begin
               n_fail++;
               $display("FAIL rnd_mpc%0d got %h exp %h",
                        i, bus.mispredict_pc, m_mis_pc);
            end
         end
         n_cmp++;
         if (num_resolved !== CB'(m_res) || num_mispredicts !== CB'(m_mis)) begin
            n_fail++;
            $display("FAIL rnd_stats%0d got %0d/%0d exp %0d/%0d",
                     i, num_resolved, num_mispredicts, CB'(m_res), CB'(m_mis));
         end
      end
   endtask

   initial begin
      pmode = 1'b0;
      reset = 1'b1;
      bus.fetch_val = 1'b0;
      bus.fetch_pc = '0;
      bus.resolve_val = 1'b0;
      bus.resolve_taken = 1'b0;
      model_reset();
      test_reset();
      test_fill();
      test_wrap();
      test_mispredict();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/lab4_branch_branch_update_queue.md
# lab4_branch_branch_update_queue

In-order queue of in-flight branch predictions sitting between fetch and the gshare direction predictor. It records each predicted branch's PC and predicted direction at fetch. When execute resolves the oldest branch, it drives the predictor's update port with the actual outcome and signals a redirect on mispredict. It also owns the predictor's shared PC port, arbitrating between fetch lookups and resolve updates.

## Interface

**Parameters**
- p_num_entries, 4: queue depth; power of two, ≥ 2.
- p_cnt_nbits, 16: width of statistics counters.

**Ports**
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_val  in  1  fetch presents a branch for prediction/enqueue.
- fetch_rdy  out  1  queue accepts the fetch branch this cycle.
- fetch_pc  in  32  PC of the fetch branch.
- fetch_pred  out  1  predicted direction returned to fetch; equals pred_prediction.
- resolve_val  in  1  execute presents the outcome of the oldest branch.
- resolve_rdy  out  1  queue non-empty.
- resolve_taken  in  1  actual direction.
- pred_pc  out  32  PC driven to predictor.
- pred_prediction  in  1  predictor output for pred_pc (combinational).
- pred_update_en  out  1  predictor update strobe.
- pred_update_val  out  1  outcome written to predictor.
- mispredict  out  1  one-cycle redirect pulse.
- mispredict_pc  out  32  PC of the mispredicted branch.
- count  out  $clog2(p_num_entries)+1  valid entries.
- num_resolved  out  p_cnt_nbits  branches resolved since reset.
- num_mispredicts  out  p_cnt_nbits  mispredicts since reset.

## Operation

- Storage: circular buffer of p_num_entries entries, each holding {pc[31:0], pred}. Head and tail pointers are log2(p_num_entries) bits and wrap naturally. Count distinguishes full from empty.
- Resolve fire = resolve_val && resolve_rdy; resolve_rdy = (count != 0).
- Port arbitration (combinational):
  - On resolve fire: pred_pc = head.pc, pred_update_en = 1, pred_update_val = resolve_taken.
  - Otherwise: pred_pc = fetch_pc, pred_update_en = 0, pred_update_val = 0.
- fetch_rdy = (count != p_num_entries) && !(resolve_val && resolve_rdy). Updates always win, so enqueue and dequeue never occur in the same cycle.
- Enqueue fire = fetch_val && fetch_rdy. On fire, write {fetch_pc, pred_prediction} at tail, then tail+1 and count+1.
- fetch_pred = pred_prediction at all times. It is only meaningful when fetch_rdy = 1.
- Resolve, correct (head.pred == resolve_taken): dequeue, head+1, count−1.
- Resolve, mispredict (head.pred != resolve_taken):
  - Squash the head and all younger entries: head = tail = 0, count = 0.
  - Register mispredict = 1 and mispredict_pc = head.pc for the next cycle.
  - Increment num_mispredicts.
- Every resolve fire increments num_resolved. Both statistics counters wrap modulo 2^p_cnt_nbits.
- The predictor sees exactly one update per resolved branch and no updates for squashed entries.

## Timing

- Reset values: count = 0, head = tail = 0, fetch_rdy = 1 (if resolve_val low), resolve_rdy = 0, pred_update_en = 0, mispredict = 0, mispredict_pc = 0, num_resolved = 0, num_mispredicts = 0.
- Reset has priority over all fires in the same cycle, including any mid-flight mispredict pulse, which is cleared.
- Fetch lookup latency: 0 cycles. The enqueued entry is visible to resolve the next cycle.
- Update latency: 0 cycles. The predictor PHT and GHR change at the clock edge ending the resolve-fire cycle.
- mispredict: asserted exactly one cycle, in the cycle after the resolve fire. It is not asserted for correct resolves.
- fetch_rdy may be 1 in the mispredict-pulse cycle. Fetch is responsible for ignoring or redirecting that cycle's branch.
- Full: fetch_rdy = 0. Empty: resolve_rdy = 0, and resolve_val is ignored (no update, no counter change).
- Pointer wrap: tail/head from p_num_entries−1 to 0 with no data loss.

## Test plan

- **Reset / idle:** assert reset 2 cycles, then idle → count = 0, resolve_rdy = 0, fetch_rdy = 1, pred_update_en = 0, counters = 0.
- **Fill / full:** with the predictor model returning 0, enqueue PCs 0x100, 0x104, 0x108, 0x10C (depth 4) → count = 4, fetch_rdy = 0. A 5th fetch_val is not accepted.
- **Correct resolves with wrap:** from full, resolve not-taken ×2, enqueue 0x200, 0x204, then resolve not-taken ×4.
  - pred_pc on each resolve = 0x100, 0x104, 0x108, 0x10C, 0x200, 0x204.
  - pred_update_val = 0 each time; mispredict never asserted; num_resolved = 6.
- **Mispredict squash:** enqueue 0x300 (pred 0), 0x304, 0x308, then resolve taken.
  - Same cycle: pred_update_en = 1, pred_update_val = 1.
  - Next cycle: mispredict = 1, mispredict_pc = 0x300, count = 0, num_mispredicts = 1.
  - mispredict = 0 the following cycle.
- **Simultaneous fetch/resolve:** count = 2, fetch_val = 1 and resolve_val = 1 → fetch_rdy = 0, pred_pc = head.pc, count becomes 1. Next cycle (resolve_val = 0) the fetch enqueues with pred_pc = fetch_pc.
- **Reset mid-operation:** assert reset in the cycle after a mispredicting resolve, with count = 3 beforehand → mispredict = 0, count = 0, counters = 0 next cycle.
